// File: rtl/pipeline_front_regs.sv
// Front-end pipeline registers of the 5-stage core: PC (F), IF/ID (D), ID/EX (E),
// plus saturating hazard counters and a sticky stall/flush handshake checker.
module pipeline_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 10,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushE,
  input  logic              pcsrcD,
  input  logic [31:0]       pcnextF,
  input  logic [31:0]       instrF,
  input  logic [31:0]       pcplus4F,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [31:0]       rd1D,
  input  logic [31:0]       rd2D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [31:0]       signimmD,
  output logic [31:0]       pcF,
  output logic [31:0]       instrD,
  output logic [31:0]       pcplus4D,
  output logic              validD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [31:0]       rd1E,
  output logic [31:0]       rd2E,
  output logic [31:0]       signimmE,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_d_q, instr_d_d;
  logic [31:0]       pc4_d_q, pc4_d_d;
  logic              valid_d_q, valid_d_d;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic [31:0]       rd1_e_q, rd1_e_d;
  logic [31:0]       rd2_e_q, rd2_e_d;
  logic [31:0]       imm_e_q, imm_e_d;
  logic [4:0]        rs_e_q, rs_e_d;
  logic [4:0]        rt_e_q, rt_e_d;
  logic [4:0]        rd_e_q, rd_e_d;
  logic              valid_e_q, valid_e_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        cnt_evt;
  logic              proto_q, proto_d;

  // Counter events: [0] stall, [1] bubble, [2] squash (a stalled branch is not a squash)
  assign cnt_evt = {pcsrcD & ~stallD, flushE, stallF};

  always_comb begin
    pc_d      = pc_q;
    instr_d_d = instr_d_q;
    pc4_d_d   = pc4_d_q;
    valid_d_d = valid_d_q;
    if (!stallF) pc_d = pcnextF;

    // Stall outranks the branch squash: the branch compare is stale while D is held
    if (!stallD) begin
      if (pcsrcD) begin
        instr_d_d = '0;
        pc4_d_d   = '0;
        valid_d_d = 1'b0;
      end else begin
        instr_d_d = instrF;
        pc4_d_d   = pcplus4F;
        valid_d_d = 1'b1;
      end
    end

    if (flushE) begin
      ctrl_e_d  = '0;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      imm_e_d   = '0;
      rs_e_d    = '0;
      rt_e_d    = '0;
      rd_e_d    = '0;
      valid_e_d = 1'b0;
    end else begin
      ctrl_e_d  = ctrlD;
      rd1_e_d   = rd1D;
      rd2_e_d   = rd2D;
      imm_e_d   = signimmD;
      rs_e_d    = rsD;
      rt_e_d    = rtD;
      rd_e_d    = rdD;
      valid_e_d = valid_d_q;
    end

    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = (cnt_evt[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_ONE : cnt_q[i];
    end

    // F and D must stall together, and a held D must always bubble E
    proto_d = proto_q | (stallF ^ stallD) | (stallD & ~flushE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_d_q <= '0;
      pc4_d_q   <= '0;
      valid_d_q <= 1'b0;
      ctrl_e_q  <= '0;
      rd1_e_q   <= '0;
      rd2_e_q   <= '0;
      imm_e_q   <= '0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      rd_e_q    <= '0;
      valid_e_q <= 1'b0;
      cnt_q     <= '0;
      proto_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_d_q <= instr_d_d;
      pc4_d_q   <= pc4_d_d;
      valid_d_q <= valid_d_d;
      ctrl_e_q  <= ctrl_e_d;
      rd1_e_q   <= rd1_e_d;
      rd2_e_q   <= rd2_e_d;
      imm_e_q   <= imm_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      rd_e_q    <= rd_e_d;
      valid_e_q <= valid_e_d;
      cnt_q     <= cnt_d;
      proto_q   <= proto_d;
    end
  end

  assign pcF        = pc_q;
  assign instrD     = instr_d_q;
  assign pcplus4D   = pc4_d_q;
  assign validD     = valid_d_q;
  assign ctrlE      = ctrl_e_q;
  assign rd1E       = rd1_e_q;
  assign rd2E       = rd2_e_q;
  assign signimmE   = imm_e_q;
  assign rsE        = rs_e_q;
  assign rtE        = rt_e_q;
  assign rdE        = rd_e_q;
  assign validE     = valid_e_q;
  assign stall_cnt  = cnt_q[0];
  assign bubble_cnt = cnt_q[1];
  assign squash_cnt = cnt_q[2];
  assign proto_err  = proto_q;

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed bench for pipeline_front_regs: a stage-level reference model checked every
// cycle, plus hand-computed expectations at the interesting points of each scenario.
module tb_pipeline_front_regs;

  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk, reset;
  logic stallF, stallD, flushE, pcsrcD;
  logic [31:0] pcnextF, instrF, pcplus4F, rd1D, rd2D, signimmD;
  logic [CTRL_W-1:0] ctrlD;
  logic [4:0] rsD, rtD, rdD;
  logic [31:0] pcF, instrD, pcplus4D, rd1E, rd2E, signimmE;
  logic validD, validE, proto_err;
  logic [CTRL_W-1:0] ctrlE;
  logic [4:0] rsE, rtE, rdE;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, squash_cnt;

  pipeline_front_regs #(.RESET_PC(32'h0000_0000), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .pcsrcD(pcsrcD), .pcnextF(pcnextF), .instrF(instrF), .pcplus4F(pcplus4F),
    .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .signimmD(signimmD), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
    .validD(validD), .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .validE(validE), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .squash_cnt(squash_cnt), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stage contents as plain variables, counters as integers
  logic [31:0] m_pc, m_instrD, m_pc4D, m_rd1E, m_rd2E, m_immE;
  logic [CTRL_W-1:0] m_ctrlE;
  logic [4:0] m_rsE, m_rtE, m_rdE;
  logic m_vD, m_vE, m_proto;
  int m_stall, m_bubble, m_squash;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_instrD = 0; m_pc4D = 0; m_vD = 0;
      m_ctrlE = 0; m_rd1E = 0; m_rd2E = 0; m_immE = 0;
      m_rsE = 0; m_rtE = 0; m_rdE = 0; m_vE = 0;
      m_stall = 0; m_bubble = 0; m_squash = 0; m_proto = 0;
    end else begin
      if (stallF != stallD || (stallD && !flushE)) m_proto = 1;
      if (stallF) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (flushE) m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
      if (pcsrcD && !stallD) m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
      // E takes what D held before this edge, so it is evaluated before D changes
      if (flushE) begin
        m_ctrlE = 0; m_rd1E = 0; m_rd2E = 0; m_immE = 0;
        m_rsE = 0; m_rtE = 0; m_rdE = 0; m_vE = 0;
      end else begin
        m_ctrlE = ctrlD; m_rd1E = rd1D; m_rd2E = rd2D; m_immE = signimmD;
        m_rsE = rsD; m_rtE = rtD; m_rdE = rdD; m_vE = m_vD;
      end
      if (!stallD) begin
        m_instrD = pcsrcD ? 32'h0 : instrF;
        m_pc4D   = pcsrcD ? 32'h0 : pcplus4F;
        m_vD     = !pcsrcD;
      end
      if (!stallF) m_pc = pcnextF;
    end
  end

  always @(negedge clk) begin
    chk("pcF", pcF, m_pc);
    chk("instrD", instrD, m_instrD);
    chk("pcplus4D", pcplus4D, m_pc4D);
    chk("validD", {31'b0, validD}, {31'b0, m_vD});
    chk("ctrlE", {22'b0, ctrlE}, {22'b0, m_ctrlE});
    chk("rd1E", rd1E, m_rd1E);
    chk("rd2E", rd2E, m_rd2E);
    chk("signimmE", signimmE, m_immE);
    chk("rsE", {27'b0, rsE}, {27'b0, m_rsE});
    chk("rtE", {27'b0, rtE}, {27'b0, m_rtE});
    chk("rdE", {27'b0, rdE}, {27'b0, m_rdE});
    chk("validE", {31'b0, validE}, {31'b0, m_vE});
    chk("stall_cnt", {28'b0, stall_cnt}, m_stall);
    chk("bubble_cnt", {28'b0, bubble_cnt}, m_bubble);
    chk("squash_cnt", {28'b0, squash_cnt}, m_squash);
    chk("proto_err", {31'b0, proto_err}, {31'b0, m_proto});
  end

  // Drive one cycle of inputs at the falling edge and wait for the next falling edge
  task automatic cyc(input logic sf, input logic sd, input logic fe, input logic ps,
                     input logic [31:0] instr, input logic [31:0] pcn);
    stallF = sf; stallD = sd; flushE = fe; pcsrcD = ps;
    instrF = instr; pcnextF = pcn; pcplus4F = pcn;
    ctrlD = instr[CTRL_W-1:0] | 10'h001;
    rd1D = instr ^ 32'hA5A5_0000; rd2D = ~instr; signimmD = {{16{instr[15]}}, instr[15:0]};
    rsD = instr[25:21]; rtD = instr[20:16]; rdD = instr[15:11];
    @(negedge clk);
    $display("cyc sF=%0b sD=%0b fE=%0b pcsrc=%0b instrF=%h -> pcF=%h instrD=%h vD=%0b vE=%0b cnt=%0d/%0d/%0d perr=%0b",
             sf, sd, fe, ps, instr, pcF, instrD, validD, validE, stall_cnt, bubble_cnt, squash_cnt, proto_err);
  endtask

  initial begin
    reset = 1'b0;
    stallF = 0; stallD = 0; flushE = 0; pcsrcD = 0;
    pcnextF = 0; instrF = 0; pcplus4F = 0; ctrlD = 0;
    rd1D = 0; rd2D = 0; signimmD = 0; rsD = 0; rtD = 0; rdD = 0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset pcF", pcF, 32'h0);
    chk("reset validD", {31'b0, validD}, 32'h0);
    chk("reset validE", {31'b0, validE}, 32'h0);
    reset = 1'b0;

    // Straight-line fetch
    cyc(0, 0, 0, 0, 32'h8C08_0004, 32'd4);
    chk("lit pcF=4", pcF, 32'd4);
    chk("lit instrD c1", instrD, 32'h8C08_0004);
    chk("lit validD c1", {31'b0, validD}, 32'h1);
    cyc(0, 0, 0, 0, 32'h0109_5020, 32'd8);
    chk("lit pcF=8", pcF, 32'd8);
    chk("lit instrD c2", instrD, 32'h0109_5020);
    chk("lit validE c2", {31'b0, validE}, 32'h1);
    chk("lit ctrlE c2", {22'b0, ctrlE}, 32'h021);
    chk("lit rsE c2", {27'b0, rsE}, 32'd8);
    chk("lit rtE c2", {27'b0, rtE}, 32'd9);

    // Load-use stall
    cyc(1, 1, 1, 0, 32'hAC0B_0008, 32'd12);
    chk("lit lu pcF", pcF, 32'd8);
    chk("lit lu instrD", instrD, 32'h0109_5020);
    chk("lit lu ctrlE", {22'b0, ctrlE}, 32'h0);
    chk("lit lu validE", {31'b0, validE}, 32'h0);
    chk("lit lu stall_cnt", {28'b0, stall_cnt}, 32'd1);
    chk("lit lu bubble_cnt", {28'b0, bubble_cnt}, 32'd1);
    chk("lit lu proto", {31'b0, proto_err}, 32'h0);
    cyc(0, 0, 0, 0, 32'hAC0B_0008, 32'd12);
    chk("lit pcF=12", pcF, 32'd12);

    // Branch taken while stalled, then branch taken for real
    cyc(1, 1, 1, 1, 32'h1000_0003, 32'd16);
    chk("lit brstall instrD", instrD, 32'hAC0B_0008);
    chk("lit brstall squash", {28'b0, squash_cnt}, 32'd0);
    cyc(0, 0, 0, 1, 32'h1000_0003, 32'd16);
    chk("lit br instrD", instrD, 32'h0);
    chk("lit br validD", {31'b0, validD}, 32'h0);
    chk("lit br pcplus4D", pcplus4D, 32'h0);
    chk("lit br squash", {28'b0, squash_cnt}, 32'd1);
    cyc(0, 0, 0, 0, 32'h2001_0001, 32'd20);
    chk("lit post-br validE", {31'b0, validE}, 32'h0);
    chk("lit post-br validD", {31'b0, validD}, 32'h1);

    // Counter saturation
    for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc(1, 1, 1, 0, 32'h2002_0002 + i, 32'd24);
    chk("lit sat stall_cnt", {28'b0, stall_cnt}, 32'd15);
    chk("lit sat bubble_cnt", {28'b0, bubble_cnt}, 32'd15);
    chk("lit sat proto", {31'b0, proto_err}, 32'h0);

    // Asynchronous reset between edges while stalled
    #2 reset = 1'b1;
    #1;
    chk("lit areset pcF", pcF, 32'h0);
    chk("lit areset instrD", instrD, 32'h0);
    chk("lit areset validD", {31'b0, validD}, 32'h0);
    chk("lit areset ctrlE", {22'b0, ctrlE}, 32'h0);
    chk("lit areset stall_cnt", {28'b0, stall_cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("lit release bubble_cnt", {28'b0, bubble_cnt}, 32'h0);
    chk("lit release squash_cnt", {28'b0, squash_cnt}, 32'h0);
    cyc(0, 0, 0, 0, 32'h8C08_0004, 32'd4);
    chk("lit restart pcF", pcF, 32'd4);

    // Handshake violation is sticky until reset
    cyc(1, 0, 0, 0, 32'h0109_5020, 32'd8);
    chk("lit proto set", {31'b0, proto_err}, 32'h1);
    chk("lit proto pcF hold", pcF, 32'd4);
    cyc(0, 0, 0, 0, 32'h0109_5020, 32'd8);
    cyc(1, 1, 1, 0, 32'hAC0B_0008, 32'd12);
    chk("lit proto sticky", {31'b0, proto_err}, 32'h1);
    #2 reset = 1'b1;
    #1 chk("lit proto cleared", {31'b0, proto_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 32'h0000_0000, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
